// File: rtl/brisc_pkg.sv
// Shared BRISC pipeline definitions: sequencer state encodings, counter width
// and the pipeline-register controls implied by each sequencer state.
package brisc_pkg;

  localparam int CNT_W = 16;

  localparam logic [2:0] ST_WAIT_LOAD = 3'd0;
  localparam logic [2:0] ST_RUN       = 3'd1;
  localparam logic [2:0] ST_STALL     = 3'd2;
  localparam logic [2:0] ST_FLUSH     = 3'd3;
  localparam logic [2:0] ST_STEP_WAIT = 3'd4;
  localparam logic [2:0] ST_HALTED    = 3'd5;

  // A bubble loads a NOP: all write, jump and stack controls of that register are 0.
  typedef struct packed {
    logic pc_en;
    logic ireg_bubble;
    logic ereg_bubble;
    logic halted;
  } seq_ctrl_t;

  function automatic seq_ctrl_t ctrl_for(input logic [2:0] st);
    seq_ctrl_t c;
    case (st)
      ST_RUN:       c = '{pc_en: 1'b1, ireg_bubble: 1'b0, ereg_bubble: 1'b0, halted: 1'b0};
      ST_STALL:     c = '{pc_en: 1'b0, ireg_bubble: 1'b1, ereg_bubble: 1'b0, halted: 1'b0};
      ST_FLUSH:     c = '{pc_en: 1'b1, ireg_bubble: 1'b1, ereg_bubble: 1'b1, halted: 1'b0};
      ST_STEP_WAIT: c = '{pc_en: 1'b0, ireg_bubble: 1'b1, ereg_bubble: 1'b0, halted: 1'b0};
      ST_HALTED:    c = '{pc_en: 1'b0, ireg_bubble: 1'b1, ereg_bubble: 1'b0, halted: 1'b1};
      default:      c = '{pc_en: 1'b0, ireg_bubble: 1'b1, ereg_bubble: 1'b1, halted: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/step_debouncer.sv
// Single-step button conditioning: 2-flop synchroniser, stability counter and
// a one-cycle pulse on each accepted press (rising edge of the debounced level).
module step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level_prev;
  logic          level_db;
  logic [CW-1:0] cnt;
  logic          stable;

  assign stable = (sync_b == level_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      level_prev <= 1'b0;
      level_db   <= 1'b0;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      sync_a     <= btn;
      sync_b     <= sync_a;
      level_prev <= sync_b;
      press      <= 1'b0;
      // Any change of the synchronised level restarts the stability window.
      if (!stable) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end else begin
        level_db <= level_prev;
        press    <= level_prev & ~level_db;
      end
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Sequencing controller for the 3-stage BRISC pipeline: program-load wait,
// RAW-hazard stalls, post-jump flushes, HALT and debounced single-step.
module pipeline_sequencer
  import brisc_pkg::*;
#(
  parameter int FLUSH_CYCLES    = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load_done,
  input  logic [3:0]       a_addr_I,
  input  logic [3:0]       b_addr_I,
  input  logic             uses_a_I,
  input  logic             uses_b_I,
  input  logic             halt_I,
  input  logic [3:0]       c_addr_E,
  input  logic             reg_write_E,
  input  logic             jump_en_W,
  input  logic             step_mode,
  input  logic             step_btn,
  output logic             pc_en,
  output logic             ireg_bubble,
  output logic             ereg_bubble,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic       hazard;
  logic       step_press;
  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [2:0] flush_left_q;
  logic [2:0] flush_left_d;
  logic       stall_inc;
  logic       flush_inc;
  logic [2:0] resume_st;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clk  (CLK),
    .rst_n(RST_N),
    .btn  (step_btn),
    .press(step_press)
  );

  // Register 0 is deliberately not excluded: BRISC r0 is a real register.
  assign hazard = reg_write_E & ((uses_a_I & (a_addr_I == c_addr_E)) |
                                 (uses_b_I & (b_addr_I == c_addr_E)));

  assign resume_st = step_mode ? ST_STEP_WAIT : ST_RUN;
  assign state     = state_q;

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (!load_done) begin
      state_d = ST_WAIT_LOAD;
    end else begin
      case (state_q)
        ST_WAIT_LOAD: state_d = resume_st;
        ST_RUN, ST_STALL: begin
          if (jump_en_W) begin
            state_d      = ST_FLUSH;
            flush_left_d = 3'(FLUSH_CYCLES);
            flush_inc    = 1'b1;
          end else if (hazard) begin
            state_d   = ST_STALL;
            stall_inc = 1'b1;
          end else if (halt_I && state_q == ST_RUN) begin
            state_d = ST_HALTED;
          end else begin
            state_d = resume_st;
          end
        end
        // Jumps seen here come from bubbled instructions and are ignored.
        ST_FLUSH: begin
          if (flush_left_q <= 3'd1) state_d = resume_st;
          else flush_left_d = flush_left_q - 3'd1;
        end
        ST_STEP_WAIT: begin
          if (!step_mode || step_press) state_d = ST_RUN;
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_WAIT_LOAD;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_WAIT_LOAD;
      flush_left_q <= 3'd0;
      pc_en        <= 1'b0;
      ireg_bubble  <= 1'b1;
      ereg_bubble  <= 1'b1;
      halted       <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      {pc_en, ireg_bubble, ereg_bubble, halted} <= ctrl_for(state_d);
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
      if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule
